// File: rtl/pixel_window_gen.sv
// ============================================================================
//  Module      : pixel_window_gen
//  Description : Streaming 3x3 neighbourhood generator (two line buffers plus
//                a shifting window) feeding the eight Sobel neighbours of
//                each interior pixel of a raster frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_window_gen #(
    parameter int LINE_LEN  = 16,
    parameter int NUM_LINES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pixel_valid,
    input  logic [7:0] pixel_in,
    output logic [7:0] pixel_pp,
    output logic [7:0] pixel_p0,
    output logic [7:0] pixel_pm,
    output logic [7:0] pixel_0p,
    output logic [7:0] pixel_0m,
    output logic [7:0] pixel_mp,
    output logic [7:0] pixel_m0,
    output logic [7:0] pixel_mm,
    output logic       window_valid,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(LINE_LEN);
    localparam int RW = $clog2(NUM_LINES);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;

    // Window registers: first letter column offset, second row offset
    logic [7:0]     pp_q, p0_q, pm_q, pp_d, p0_d, pm_d;
    logic [7:0]     zp_q, c00_q, zm_q, zp_d, c00_d, zm_d;
    logic [7:0]     mp_q, m0_q, mm_q, mp_d, m0_d, mm_d;
    logic           window_valid_q, window_valid_d;
    logic           frame_done_q, frame_done_d;

    // line1 holds the previous row, line2 the row before that
    logic [7:0]     line1_mem [LINE_LEN];
    logic [7:0]     line2_mem [LINE_LEN];

    logic           accept;
    logic           last_col;
    logic           last_row;
    logic [7:0]     t1;
    logic [7:0]     t2;

    always_comb begin
        accept   = (state_q == ACTIVE) && pixel_valid && !start;
        last_col = (col_q == CW'(LINE_LEN - 1));
        last_row = (row_q == RW'(NUM_LINES - 1));
        t1       = line1_mem[col_q];
        t2       = line2_mem[col_q];
    end

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        pp_d           = pp_q;
        p0_d           = p0_q;
        pm_d           = pm_q;
        zp_d           = zp_q;
        c00_d          = c00_q;
        zm_d           = zm_q;
        mp_d           = mp_q;
        m0_d           = m0_q;
        mm_d           = mm_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;

        if (start) begin
            // Restart wins over any same-cycle pixel, which is dropped
            state_d = ACTIVE;
            col_d   = '0;
            row_d   = '0;
        end else if (accept) begin
            mp_d  = zp_q;
            m0_d  = c00_q;
            mm_d  = zm_q;
            zp_d  = pp_q;
            c00_d = p0_q;
            zm_d  = pm_q;
            pp_d  = pixel_in;
            p0_d  = t1;
            pm_d  = t2;

            window_valid_d = (col_q >= CW'(2)) && (row_q >= RW'(2));

            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d        = '0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            pp_q           <= '0;
            p0_q           <= '0;
            pm_q           <= '0;
            zp_q           <= '0;
            c00_q          <= '0;
            zm_q           <= '0;
            mp_q           <= '0;
            m0_q           <= '0;
            mm_q           <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            pp_q           <= pp_d;
            p0_q           <= p0_d;
            pm_q           <= pm_d;
            zp_q           <= zp_d;
            c00_q          <= c00_d;
            zm_q           <= zm_d;
            mp_q           <= mp_d;
            m0_q           <= m0_d;
            mm_q           <= mm_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Line storage is deliberately unreset; rows 0-1 are never emitted
    always_ff @(posedge clock) begin
        if (accept) begin
            line2_mem[col_q] <= t1;
            line1_mem[col_q] <= pixel_in;
        end
    end

    assign pixel_pp     = pp_q;
    assign pixel_p0     = p0_q;
    assign pixel_pm     = pm_q;
    assign pixel_0p     = zp_q;
    assign pixel_0m     = zm_q;
    assign pixel_mp     = mp_q;
    assign pixel_m0     = m0_q;
    assign pixel_mm     = mm_q;
    assign window_valid = window_valid_q;
    assign busy         = (state_q == ACTIVE);
    assign frame_done   = frame_done_q;

endmodule

`default_nettype wire

// File: doc/pixel_window_gen.md
# pixel_window_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of `dut_core`. It accepts a raster-order 8-bit pixel stream, one pixel per accepted cycle. Two line buffers plus a shifting window register present the eight Sobel neighbours of each interior pixel on `pixel_pp`…`pixel_mm`, qualified by `window_valid`. Naming matches `dut_core`: first letter is the column offset, second the row offset (m = −1, 0 = 0, p = +1) relative to the window centre.

## Interface
- `LINE_LEN`, 16, pixels per line; legal ≥ 3.
- `NUM_LINES`, 16, lines per frame; legal ≥ 3.
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin (or restart) a frame; single-cycle pulse.
- `pixel_valid`  in  1  `pixel_in` is valid this cycle.
- `pixel_in`  in  8  raster pixel: row 0 col 0 first, columns fastest.
- `pixel_pp`, `pixel_p0`, `pixel_pm`, `pixel_0p`, `pixel_0m`, `pixel_mp`, `pixel_m0`, `pixel_mm`  out  8 each  window neighbours; centre not output.
- `window_valid`  out  1  one-cycle strobe: neighbour outputs form a complete window.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after last pixel of frame accepted.

## Operation
- States:
  - IDLE: `busy` = 0; `pixel_valid` is ignored.
  - ACTIVE: `busy` = 1.
- IDLE → ACTIVE on `start`. ACTIVE → IDLE when pixel (col `LINE_LEN`−1, row `NUM_LINES`−1) is accepted.
- Accept = ACTIVE && `pixel_valid` && !`start`. There is no backpressure; the block is always ready in ACTIVE.
- Counters:
  - `col` (0..`LINE_LEN`−1) and `row` (0..`NUM_LINES`−1), width `$clog2` of each parameter.
  - `col` advances on each accept and wraps to 0 at `LINE_LEN`−1, incrementing `row`.
- Line buffers: `line1` holds row−1 and `line2` holds row−2, each `LINE_LEN`×8.
  - On accept at column c: read `t1` = `line1[c]` and `t2` = `line2[c]`.
  - Then write `line2[c]` ← `t1` and `line1[c]` ← `pixel_in`.
- Window shift on every accept (newest column becomes the "p" column):
  - `pixel_pm` ← `t2`, `pixel_p0` ← `t1`, `pixel_pp` ← `pixel_in`.
  - 0-column ← old p-column, using an internal centre register `c00` ← old `pixel_p0`.
  - m-column ← old 0-column (`pixel_m0` ← `c00`).
- `window_valid` is asserted for the accept where `col` ≥ 2 and `row` ≥ 2. The centre is then (`col`−1, `row`−1).
  - Only interior centres are emitted: (`LINE_LEN`−2)×(`NUM_LINES`−2) windows per frame.
- The window shifts across line wrap too. Stale contents at `col` < 2 are never flagged valid.
- Line buffers are not cleared on `start` or reset. Rows 0–1 are never emitted, so stale data is never observed.
- `start` while ACTIVE restarts the frame: counters go to 0, the same-cycle pixel is dropped, and no `window_valid` or `frame_done` is produced for that cycle.
- `start` and last-pixel accept never coincide, because `start` blocks the accept. `start` wins.

## Timing
- Async `reset_n` low drives immediately:
  - state IDLE; `col`, `row` = 0;
  - all `pixel_*` = 0x00, `c00` = 0;
  - `window_valid` = 0, `busy` = 0, `frame_done` = 0.
  - Reset deassertion is synchronised externally.
- `busy` rises the cycle after the `start` edge and falls the cycle after the last accept.
- Latency: the window is registered. `window_valid` and the matching `pixel_*` appear the cycle after the accepting edge, for exactly one cycle.
- `pixel_*` hold their last values when nothing is accepted. They shift only on accept.
- `frame_done` occurs in the same cycle as the final `window_valid`, i.e. 1 cycle after the last accept.
- `pixel_valid` gaps of any length stall the pipeline without loss.
- Throughput: 1 window per clock at full rate.

## Test plan
- Reset/idle: hold `reset_n` = 0, then release; drive `pixel_valid` = 1 without `start` → all outputs 0, no `window_valid`, `busy` = 0.
- Basic frame (`LINE_LEN` = `NUM_LINES` = 4, pixel = 16·row+col, continuous valid):
  - the first `window_valid` comes 1 cycle after pixel (2,2) is accepted, with `pixel_mm`=0x00, `pixel_0m`=0x01, `pixel_pm`=0x02, `pixel_m0`=0x10, `pixel_p0`=0x12, `pixel_mp`=0x20, `pixel_0p`=0x21, `pixel_pp`=0x22;
  - exactly 4 windows in total; the last is centred at (2,2) with `pixel_pp`=0x33;
  - `frame_done` coincides with the last window.
- Bubbles: same frame with `pixel_valid` toggling 1010… → identical window values and order; outputs hold during gaps.
- Restart mid-frame: `start` pulsed at pixel (1,2) together with `pixel_valid` → that pixel is dropped; a fresh frame yields 4 correct windows and one `frame_done`.
- Async reset mid-frame at row 2 → outputs are 0 immediately, no `frame_done`; a following `start` + full frame behaves as the basic frame.
- Back-to-back frames: `start` in the cycle after `frame_done` → the second frame's windows are correct, with no stale-row window emitted.
